// File: rtl/spram_banked_memory.sv
// spram_banked_memory
//
// Main memory built from one or two 64 KiB banks. Each bank is a pair of
// 16Kx16 single-port RAMs, one for each 16-bit half of the 32-bit word.
// A valid/ready handshake fronts the banks. Each bank tracks its own idle
// time. After IDLE_CYCLES cycles without an accepted access it drops into
// STANDBY. A later request to that bank stalls for WAKE_CYCLES cycles
// before it is accepted.
//
// Ports
//   clk      system clock
//   rstn     synchronous active-low reset
//   valid    access request
//   write    1 = write, 0 = read
//   wmask    byte write enables, bit i covers wdata[8i+7:8i]
//   wdata    write data
//   addr     byte address: [15:2] word index, [16] bank select when BANKS=2
//   ready    request accepted this cycle (combinational)
//   rdata    read data, valid the cycle after an accepted read, then held
//   standby  STANDBY pin level of each bank

module spram_banked_memory #(
  parameter int BANKS       = 1,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 3,
  parameter int ADDR_WIDTH  = 16 + $clog2(BANKS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  logic                  write,
  input  logic [3:0]            wmask,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic [BANKS-1:0]      standby
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_STANDBY,
    ST_WAKE
  } bank_state_e;

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [3:0]        WAKE_LAST = 4'(WAKE_CYCLES - 1);

  logic              bank_sel;
  logic              sel_active;
  logic [BANKS-1:0]  bank_active;
  logic [BANKS-1:0][31:0] bank_dout;
  logic              unused_addr_bits;

  logic              rd_pend_q;
  logic              rd_sel_q;
  logic [31:0]       rd_hold_q;
  logic [31:0]       rd_dout;

  assign unused_addr_bits = ^addr[1:0];

  if (BANKS == 2) begin : g_sel_two
    assign bank_sel = addr[16];
  end else begin : g_sel_one
    assign bank_sel = 1'b0;
  end

  // Only registered state, valid and the bank bit reach ready, so the
  // handshake stays off the RAM output path.
  assign sel_active = (BANKS == 2 && bank_sel) ? bank_active[BANKS-1] : bank_active[0];
  assign ready      = valid & sel_active & rstn;

  // The RAMs re-read their address on every idle cycle, so the word
  // returned by the last accepted read is kept in rd_hold_q and replayed
  // until another read completes.
  assign rd_dout = (BANKS == 2 && rd_sel_q) ? bank_dout[BANKS-1] : bank_dout[0];
  assign rdata   = rd_pend_q ? rd_dout : rd_hold_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pend_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      rd_pend_q <= ready & ~write;
      if (ready & ~write) begin
        rd_sel_q <= bank_sel;
      end
      rd_hold_q <= rdata;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    bank_state_e       state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [3:0]        wake_q, wake_d;
    logic              hit;
    logic              acc;
    logic              bank_wren;

    assign hit            = valid && (bank_sel == 1'(b));
    assign acc            = ready && hit;
    assign bank_wren      = acc && write;
    assign bank_active[b] = (state_q == ST_ACTIVE);
    assign standby[b]     = (state_q == ST_STANDBY);

    always_ff @(posedge clk) begin
      if (!rstn) begin
        state_q <= ST_ACTIVE;
        idle_q  <= '0;
        wake_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
      end
    end

    // The idle and wake thresholds are tested against the count before
    // it increments. The state change then lands on the same edge that
    // would bring the counter up to its limit.
    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
        ST_ACTIVE: begin
          if (acc) begin
            idle_d = '0;
          end else begin
            if (idle_q != IDLE_MAX) begin
              idle_d = idle_q + 1'b1;
            end
            if (IDLE_CYCLES != 0 && idle_q == IDLE_LAST) begin
              state_d = ST_STANDBY;
              idle_d  = '0;
            end
          end
        end
        ST_STANDBY: begin
          if (hit) begin
            state_d = ST_WAKE;
            wake_d  = '0;
          end
        end
        ST_WAKE: begin
          if (wake_q == WAKE_LAST) begin
            state_d = ST_ACTIVE;
            idle_d  = '0;
          end else begin
            wake_d = wake_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
        end
      endcase
    end

    spram_banked_memory_spram u_lo (
      .clk        (clk),
      .address    (addr[15:2]),
      .datain     (wdata[15:0]),
      .maskwren   ({wmask[1], wmask[1], wmask[0], wmask[0]}),
      .wren       (bank_wren),
      .chipselect (1'b1),
      .standby    (standby[b]),
      .sleep      (1'b0),
      .poweroff   (1'b1),
      .dataout    (bank_dout[b][15:0])
    );

    spram_banked_memory_spram u_hi (
      .clk        (clk),
      .address    (addr[15:2]),
      .datain     (wdata[31:16]),
      .maskwren   ({wmask[3], wmask[3], wmask[2], wmask[2]}),
      .wren       (bank_wren),
      .chipselect (1'b1),
      .standby    (standby[b]),
      .sleep      (1'b0),
      .poweroff   (1'b1),
      .dataout    (bank_dout[b][31:16])
    );
  end

endmodule

// spram_banked_memory_spram
//
// Behavioural 16Kx16 single-port RAM with the SB_SPRAM256KA pin set.
// maskwren enables one nibble per bit. The RAM does a read whenever it is
// enabled and wren is low. dataout is registered and holds across writes.
//
// Ports
//   clk, address, datain, maskwren, wren, chipselect, standby, sleep,
//   poweroff (active-low), dataout

module spram_banked_memory_spram (
  input  logic        clk,
  input  logic [13:0] address,
  input  logic [15:0] datain,
  input  logic [3:0]  maskwren,
  input  logic        wren,
  input  logic        chipselect,
  input  logic        standby,
  input  logic        sleep,
  input  logic        poweroff,
  output logic [15:0] dataout
);

  logic [15:0] mem [16384];
  logic        enabled;

  assign enabled = chipselect & ~standby & ~sleep & poweroff;

  always_ff @(posedge clk) begin
    if (enabled) begin
      if (wren) begin
        for (int n = 0; n < 4; n++) begin
          if (maskwren[n]) begin
            mem[address][4*n +: 4] <= datain[4*n +: 4];
          end
        end
      end else begin
        dataout <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_spram_banked_memory.sv
// tb_spram_banked_memory
//
// Bench for a two-bank instance with IDLE_CYCLES=4 and WAKE_CYCLES=3.
// A negedge monitor keeps a word-level memory model. Each accepted read
// queues the data it should return, and the monitor compares that entry
// one cycle later. The main sequence covers reset, zero-wait access,
// byte masking, rdata hold, standby entry and wake-up timing, the
// idle-threshold race and a reset during wake-up.

module tb_spram_banked_memory;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [16:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic [1:0]  standby;

  int n_checks = 0;
  int n_passed = 0;
  int waits;

  logic [31:0] exp_q [$];
  logic [31:0] model_mem [int];
  logic        rd_pend = 1'b0;

  spram_banked_memory #(
    .BANKS       (2),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (3)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .valid   (valid),
    .write   (write),
    .wmask   (wmask),
    .wdata   (wdata),
    .addr    (addr),
    .ready   (ready),
    .rdata   (rdata),
    .standby (standby)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request and holds it until ready is seen, then checks the
  // number of stalled cycles. Returns just after the accepting edge.
  task automatic applyStimulus(input logic w, input logic [16:0] a, input logic [31:0] d,
                               input logic [3:0] m, input int exp_waits, input string tag);
    int n = 0;
    valid = 1'b1;
    write = w;
    addr  = a;
    wdata = d;
    wmask = m;
    @(negedge clk);
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput(tag, 32'(n), 32'(exp_waits));
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Scoreboard: model accepted writes, queue and later compare reads.
  always @(negedge clk) begin
    int key;
    logic [31:0] word;
    if (rd_pend && exp_q.size() > 0) begin
      checkOutput("sb_rdata", rdata, exp_q.pop_front());
    end
    rd_pend = valid && ready && !write;
    if (valid && ready) begin
      key = int'(addr[16:2]);
      if (write) begin
        word = model_mem.exists(key) ? model_mem[key] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        model_mem[key] = word;
      end else begin
        exp_q.push_back(model_mem.exists(key) ? model_mem[key] : 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstn  = 1'b0;
    valid = 1'b0;
    write = 1'b0;
    wmask = 4'h0;
    wdata = 32'h0;
    addr  = 17'h0;

    // Reset state, with a request pending to show ready is gated.
    @(posedge clk); #1;
    valid = 1'b1;
    addr  = 17'h00010;
    @(negedge clk);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_standby", standby, 2'b00);
    checkOutput("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Both banks idle from reset: standby rises on the 5th cycle.
    repeat (4) @(negedge clk);
    checkOutput("idle_sb_c4", standby, 2'b00);
    @(negedge clk);
    checkOutput("idle_sb_c5", standby, 2'b11);

    // Write to bank 0 while it sleeps: standby falls at t+1, ready at t+4.
    @(posedge clk); #1;
    valid = 1'b1;
    write = 1'b1;
    addr  = 17'h00010;
    wdata = 32'hDEADBEEF;
    wmask = 4'hF;
    @(negedge clk);
    checkOutput("wake_t_ready", ready, 1'b0);
    waits = 1;
    @(negedge clk);
    checkOutput("wake_sb_fall", standby, 2'b10);
    while (!ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    checkOutput("wake_stall", 32'(waits), 32'd4);
    @(posedge clk); #1;
    valid = 1'b0;

    // Write then read back with zero wait states.
    applyStimulus(1'b0, 17'h00010, 32'h0, 4'h0, 0, "rd_0010_wait");
    @(negedge clk);
    checkOutput("rd_deadbeef", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Byte masking.
    applyStimulus(1'b1, 17'h00020, 32'h11223344, 4'hF, 0, "wr_0020_full");
    applyStimulus(1'b1, 17'h00020, 32'hAABBCCDD, 4'b0101, 0, "wr_0020_mask");
    applyStimulus(1'b0, 17'h00020, 32'h0, 4'h0, 0, "rd_0020_wait");
    @(negedge clk);
    checkOutput("rd_masked", rdata, 32'h11BB33DD);
    @(posedge clk); #1;

    // A write must not disturb the held read data.
    applyStimulus(1'b1, 17'h00020, 32'hFFFFFFFF, 4'hF, 0, "wr_0020_over");
    @(negedge clk);
    checkOutput("rd_hold_wr", rdata, 32'h11BB33DD);
    @(posedge clk); #1;
    applyStimulus(1'b0, 17'h00020, 32'h0, 4'h0, 0, "rd_0020_over");

    // Bank 0 busy every cycle while bank 1 stays asleep.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0] == 1'b0, 17'h00004, 32'h04040000 + 32'(i), 4'hF, 0, "b0_nostall");
    end
    checkOutput("b0_busy_sb", standby, 2'b10);

    // Bank 1 wakes. Bank 0 idles out meanwhile on its own counter.
    applyStimulus(1'b1, 17'h10004, 32'hCAFEF00D, 4'hF, 4, "b1_wake_stall");
    checkOutput("b1_woke_sb", standby, 2'b01);
    applyStimulus(1'b0, 17'h10004, 32'h0, 4'h0, 0, "b1_rd_wait");
    applyStimulus(1'b0, 17'h00004, 32'h0, 4'h0, 4, "b0_rd_wake");

    // Access on the threshold cycle: the access wins, the count restarts.
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b0, 17'h00010, 32'h0, 4'h0, 0, "race_rd_wait");
    checkOutput("race_sb", standby[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("race_sb_a8", standby[0], 1'b0);
    @(posedge clk); #1;
    checkOutput("race_sb_a9", standby[0], 1'b1);

    // Reset while bank 0 is waking.
    valid = 1'b1;
    write = 1'b0;
    addr  = 17'h00010;
    @(posedge clk); #1;
    checkOutput("mw_sb_wake", standby[0], 1'b0);
    checkOutput("mw_ready_wake", ready, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    checkOutput("mw_rst_ready", ready, 1'b0);
    checkOutput("mw_rst_sb", standby, 2'b00);
    checkOutput("mw_rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("mw_post_ready", ready, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    applyStimulus(1'b0, 17'h10004, 32'h0, 4'h0, 0, "mw_b1_rd");

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/spram_banked_memory.md
# spram_banked_memory

Parametrised successor to the two-SPRAM main-memory wrapper. It spans one or two 64 KiB banks, each bank a pair of SB_SPRAM256KA. It adds a valid/ready handshake and per-bank idle-driven STANDBY power management with a stalling wake-up sequence. It sits between the Pipeline memory port and the boot-BRAM mux in the UP5K top level, replacing the fixed 64 KiB main memory.

## Interface
- BANKS, 1: number of 64 KiB banks; legal values are 1 and 2, and each bank uses 2 SPRAMs.
- IDLE_CYCLES, 16: cycles a bank must go without an accepted access before it enters STANDBY; 0 disables STANDBY.
- WAKE_CYCLES, 3: cycles STANDBY must be deasserted before a bank accepts an access; legal range is 1..15.
- ADDR_WIDTH, 16+$clog2(BANKS): width of the byte address.

- clk  in  1  system clock
- rstn  in  1  synchronous, active-low reset
- valid  in  1  access request
- write  in  1  1 = write, 0 = read
- wmask  in  4  byte write enables; bit i covers wdata[8i+7:8i]
- wdata  in  32  write data
- addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored, bits [15:2] form the word index, and bit 16 selects the bank when BANKS=2
- ready  out  1  request accepted this cycle
- rdata  out  32  read data
- standby  out  BANKS  current STANDBY pin level of each bank

## Operation
- **Pin ties.** Each SPRAM has CHIPSELECT=1, SLEEP=0, POWEROFF=1.
  - The low SPRAM takes MASKWREN {wmask[1],wmask[1],wmask[0],wmask[0]}.
  - The high SPRAM takes MASKWREN {wmask[3],wmask[3],wmask[2],wmask[2]}.
- **Per-bank state machine:** ACTIVE, STANDBY, WAKE.
  - **ACTIVE:** the idle counter increments each cycle with no accepted access to this bank. It clears on an accepted access to this bank and saturates at IDLE_CYCLES. When the counter equals IDLE_CYCLES (and IDLE_CYCLES≠0) with no access that cycle, the state goes to STANDBY.
  - **STANDBY:** the bank's standby bit is 1. When valid is seen with the address selecting this bank, the state goes to WAKE, the standby bit drops to 0, and the wake counter clears.
  - **WAKE:** the wake counter increments each cycle. When it reaches WAKE_CYCLES the state goes to ACTIVE with the idle counter cleared. WAKE always completes, even if valid drops mid-wake.
- **Acceptance.** ready = valid & (selected bank ACTIVE) & rstn. An accepted write drives WREN to the selected bank only, gated by wmask. An accepted read drives WREN=0.
- **Read data.**
  - rdata appears on the cycle after acceptance, muxed by a bank-select register captured at acceptance.
  - rdata is held stable until the cycle after the next accepted read.
  - Writes do not disturb rdata.
- **Simultaneous events.**
  - If the idle threshold is reached in the same cycle as an accepted access, the access wins: the counter clears and the bank stays ACTIVE.
  - The unselected bank's counter keeps running independently.
- **Reset (rstn=0 at a clock edge).**
  - All banks go ACTIVE, all counters clear, and standby = 0.
  - ready = 0 while rstn = 0, and the bank-select register clears.
  - Reset asserted mid-WAKE or mid-STANDBY returns the bank to ACTIVE on the next edge.
  - SPRAM contents are not cleared.
- **Address wrap.** Addresses at or above BANKS×64 KiB alias modulo ADDR_WIDTH.

## Timing
- **Reset values:** ready=0, standby=0, rdata=0. rdata is the registered mux output, with the bank select reset to 0.
- **Active bank:** ready is combinational in the request cycle, giving zero wait states. Read latency is 1 cycle. Back-to-back accesses are sustained every cycle.
- **Bank in STANDBY, valid first seen at cycle t:**
  - standby falls at t+1.
  - ready=1 first at t+1+WAKE_CYCLES.
  - rdata is valid at t+2+WAKE_CYCLES.
  - The requester must hold valid, write, wmask, wdata and addr stable until ready.
- **Entering STANDBY:** with the last accepted access at cycle a, standby rises at a+IDLE_CYCLES+1.
- **Critical path:** ready depends combinationally on valid, addr[16] and registered state only.

## Test plan
1. **Write then read.** BANKS=1. Write 32'hDEADBEEF to 0x0010 with wmask=4'hF, then read 0x0010 → ready=1 in both request cycles and rdata=32'hDEADBEEF one cycle after the read.
2. **Byte masking.** Write 32'h11223344 to 0x0020 with mask 4'hF, then write 32'hAABBCCDD with mask 4'b0101 → a read returns 32'h11BB33DD.
3. **Standby and wake.** IDLE_CYCLES=4, WAKE_CYCLES=3. Stay idle after a reset → standby rises on the 5th cycle after reset release. A read of 0x0010 at cycle t → standby=0 at t+1, ready at t+4, data at t+5.
4. **Independent banks.** BANKS=2. Access 0x0000_0004 every cycle for 20 cycles → standby=2'b10 after bank 1 times out. Write 0x0001_0004 → that write stalls for WAKE_CYCLES+1 cycles, and bank 0 is never stalled.
5. **Threshold race.** IDLE_CYCLES=4: an access that lands exactly on the threshold cycle → standby stays 0 and the counter restarts.
6. **Reset mid-wake.** Assert rstn=0 during WAKE → next cycle state is ACTIVE, standby=0, ready=0. Release rstn → the first request is accepted with zero wait states, and earlier written data is still readable.
